// File: rtl/pc_fetch_sequencer_if.sv
// Bus bundle between the fetch sequencer and its surroundings: program
// counter, instruction memory and the execute datapath.
interface pc_fetch_sequencer_if;
    logic        start;
    logic        step_mode;
    logic [7:0]  pc;
    logic        enable_increment;
    logic        mem_req;
    logic [7:0]  mem_addr;
    logic        mem_ack;
    logic [7:0]  mem_rdata;
    logic [7:0]  instr;
    logic        instr_valid;
    logic        exec_done;
    logic        stall;
    logic        halted;
    logic        err_timeout;
    logic [15:0] instr_count;

    // Sequencer side
    modport master (
        input  start, step_mode, pc, mem_ack, mem_rdata, exec_done, stall,
        output enable_increment, mem_req, mem_addr, instr, instr_valid,
               halted, err_timeout, instr_count
    );

    // Environment side: counter, memory and datapath
    modport slave (
        output start, step_mode, pc, mem_ack, mem_rdata, exec_done, stall,
        input  enable_increment, mem_req, mem_addr, instr, instr_valid,
               halted, err_timeout, instr_count
    );
endinterface

// File: rtl/pc_fetch_sequencer.sv
// Fetch/execute/advance control FSM for an 8-bit program counter.
// Fetches at pc, holds the instruction for the datapath, pulses the counter
// increment once per retired instruction, and halts on the halt opcode or
// when instruction memory fails to acknowledge in time.
module pc_fetch_sequencer #(
    parameter logic [7:0]  HALT_OPCODE = 8'hFF,
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    pc_fetch_sequencer_if.master   bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXECUTE,
        S_INCR,
        S_HALTED
    } state_t;

    // Wait counter value during the last allowed FETCH cycle
    localparam logic [7:0] LAST_WAIT = 8'(ACK_TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  wait_q,  wait_d;
    logic [7:0]  instr_q, instr_d;
    logic        valid_q, valid_d;
    logic        err_q,   err_d;
    logic [15:0] count_q, count_d;

    // Next-state and register update decode
    always_comb begin
        state_d = state_q;
        wait_d  = '0;        // zero everywhere outside FETCH, so FETCH starts at 0
        instr_d = instr_q;
        valid_d = 1'b0;
        err_d   = err_q;
        count_d = count_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                wait_d = wait_q + 8'd1;
                // An ack in the last allowed cycle takes priority over the timeout
                if (bus.mem_ack) begin
                    instr_d = bus.mem_rdata;
                    if (bus.mem_rdata == HALT_OPCODE) begin
                        state_d = S_HALTED;
                    end else begin
                        state_d = S_EXECUTE;
                        valid_d = 1'b1;
                    end
                end else if (wait_q == LAST_WAIT) begin
                    state_d = S_HALTED;
                    err_d   = 1'b1;
                end
            end
            S_EXECUTE: begin
                if (bus.exec_done && !bus.stall) begin
                    state_d = S_INCR;
                end
            end
            S_INCR: begin
                count_d = count_q + 16'd1;
                state_d = bus.step_mode ? S_IDLE : S_FETCH;
            end
            S_HALTED: begin
                state_d = S_HALTED;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            wait_q  <= '0;
            instr_q <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            count_q <= count_d;
        end
    end

    assign bus.mem_req          = (state_q == S_FETCH);
    assign bus.mem_addr         = (state_q == S_FETCH) ? bus.pc : '0;
    assign bus.enable_increment = (state_q == S_INCR);
    assign bus.halted           = (state_q == S_HALTED);
    assign bus.instr            = instr_q;
    assign bus.instr_valid      = valid_q;
    assign bus.err_timeout      = err_q;
    assign bus.instr_count      = count_q;

endmodule
